seven_segment_capture: RTL

- Receive-side counterpart of the multiplexed seven-segment driver.
- Watches a scanned anode/cathode bus, which is either looped back from the driver outputs or read from the board pins, and rebuilds the per-digit 4-bit values and decimal points.
- Used for on-board self-check and regression, where the captured values are compared against the counter values that produced them.
- Reports a completed frame, undecodable patterns, bus contention and a stalled scan.

---
 rtl/seven_segment_capture.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/seven_segment_capture.sv
// Receive side of the multiplexed seven-segment driver: watches the scanned anode/cathode
// bus and rebuilds per-digit values, decimal points, frame completion and bus health flags.
module seven_segment_capture #(
  parameter int NUM_SEGMENTS   = 4,
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 400000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_SEGMENTS-1:0]      anode,
  input  logic [7:0]                   cathode,
  output logic [NUM_SEGMENTS-1:0][3:0] encoded,
  output logic [NUM_SEGMENTS-1:0]      digit_point,
  output logic [NUM_SEGMENTS-1:0]      digit_valid,
  output logic                         frame_done,
  output logic                         pattern_err,
  output logic                         multi_err,
  output logic                         stalled
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;

  // Returns {hit, value}; blank and any non-hex pattern miss.
  function automatic logic [4:0] decode_glyph(input logic [6:0] p);
    case (p)
      7'h3F:   return {1'b1, 4'h0};
      7'h06:   return {1'b1, 4'h1};
      7'h5B:   return {1'b1, 4'h2};
      7'h4F:   return {1'b1, 4'h3};
      7'h66:   return {1'b1, 4'h4};
      7'h6D:   return {1'b1, 4'h5};
      7'h7D:   return {1'b1, 4'h6};
      7'h07:   return {1'b1, 4'h7};
      7'h7F:   return {1'b1, 4'h8};
      7'h6F:   return {1'b1, 4'h9};
      7'h77:   return {1'b1, 4'hA};
      7'h7C:   return {1'b1, 4'hB};
      7'h39:   return {1'b1, 4'hC};
      7'h5E:   return {1'b1, 4'hD};
      7'h79:   return {1'b1, 4'hE};
      7'h71:   return {1'b1, 4'hF};
      default: return 5'b0;
    endcase
  endfunction

  logic [NUM_SEGMENTS-1:0] anode_p0, anode_p1, anode_p2;
  logic [7:0]              cathode_p0, cathode_p1, cathode_p2;
  logic [SW-1:0]           cnt, cnt_nxt;
  logic [TW-1:0]           tcnt;
  logic [1:0]              state, state_nxt;
  logic [NUM_SEGMENTS-1:0] seen, seen_cap, low;
  logic                    sample_same, anode_moved, settled, any_low, one_low;
  logic                    evaluate, capture, multi_hit, frame_hit;
  logic [4:0]              glyph;

  // Stage p0/p1: two-flop synchronizer; p2 holds the previous synchronized sample.
  // Reset to the blank bus so the first real samples do not look like a lit digit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      anode_p0   <= '1;
      anode_p1   <= '1;
      anode_p2   <= '1;
      cathode_p0 <= '1;
      cathode_p1 <= '1;
      cathode_p2 <= '1;
    end else begin
      anode_p0   <= anode;
      anode_p1   <= anode_p0;
      anode_p2   <= anode_p1;
      cathode_p0 <= cathode;
      cathode_p1 <= cathode_p0;
      cathode_p2 <= cathode_p1;
    end
  end

  assign sample_same = (anode_p1 == anode_p2) && (cathode_p1 == cathode_p2);
  assign anode_moved = (anode_p1 != anode_p2);
  assign cnt_nxt     = !sample_same ? SW'(1) :
                       (cnt == SETTLE_MAX) ? cnt : cnt + SW'(1);
  assign settled     = (cnt_nxt == SETTLE_MAX);
  assign low         = ~anode_p1;
  assign any_low     = |low;
  assign one_low     = any_low && ((low & (low - NUM_SEGMENTS'(1))) == '0);
  assign glyph       = decode_glyph(~cathode_p1[6:0]);

  // Settling is judged on the next counter value so a capture lands on the settling edge.
  assign evaluate = settled && ((state != HOLD) || anode_moved);

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    multi_hit = 1'b0;
    if (evaluate) begin
      if (one_low) begin
        capture   = 1'b1;
        state_nxt = HOLD;
      end else if (any_low) begin
        multi_hit = 1'b1;
        state_nxt = HOLD;
      end else begin
        state_nxt = IDLE;
      end
    end else if (state == HOLD) begin
      if (anode_moved) state_nxt = any_low ? SETTLE : IDLE;
    end else if (state == IDLE) begin
      if (any_low) state_nxt = SETTLE;
    end else if (state != SETTLE) begin
      state_nxt = IDLE;
    end
  end

  assign seen_cap  = seen | low;
  assign frame_hit = capture && (&seen_cap);

  // Stage p3: capture registers, frame tracking and event pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      tcnt        <= '0;
      seen        <= '0;
      encoded     <= '0;
      digit_point <= '0;
      digit_valid <= '0;
      frame_done  <= 1'b0;
      pattern_err <= 1'b0;
      multi_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      tcnt        <= anode_moved ? '0 :
                     (tcnt == TIMEOUT_MAX) ? tcnt : tcnt + TW'(1);
      frame_done  <= frame_hit;
      pattern_err <= capture && !glyph[4];
      multi_err   <= multi_hit;
      if (capture) begin
        seen <= frame_hit ? '0 : seen_cap;
        for (int k = 0; k < NUM_SEGMENTS; k++) begin
          if (low[k]) begin
            digit_point[k] <= ~cathode_p1[7];
            digit_valid[k] <= glyph[4];
            if (glyph[4]) encoded[k] <= glyph[3:0];
          end
        end
      end
    end
  end

  assign stalled = (tcnt == TIMEOUT_MAX);

endmodule
